pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Detects load-use hazards, resolves taken branches at the EX/MEM stage, and freezes the pipeline while data memory is not ready.
- Drives the write-enable and flush/bubble controls of every pipeline register and the PC.
- Contains a small wait-state FSM with a memory-timeout watchdog.

---
 rtl/hazard_pkg.sv | 6 +
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 14 +
 rtl/pipeline_hazard_ctrl.sv | 111 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
package hazard_pkg;
   typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;
   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] X0 = 5'd0;
endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an IF/ID source register that matches a pending load destination.
module load_use_detect
   import hazard_pkg::*;
(
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic             use_rs1,
   input  logic             use_rs2,
   input  logic             memread,
   input  logic [REG_W-1:0] rd,
   output logic             hazard
);
   assign hazard = memread && rd != X0 && ((use_rs1 && rs1 == rd) || (use_rs2 && rs2 == rd));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for a 5-stage pipeline with memory-wait watchdog.
// Optional perf counters are built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             id_ex_memread,
   input  logic [REG_W-1:0] id_ex_rd,
   input  logic             ex_mem_branch,
   input  logic             ex_mem_zero,
   input  logic             ex_mem_memread,
   input  logic             ex_mem_memwrite,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_src_branch,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_bubble,
   output logic             ex_mem_write,
   output logic             ex_mem_flush,
   output logic             mem_wb_bubble,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);
   localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);
   state_t     state, state_n;
   logic [7:0] wait_cnt, wait_n;
   logic       mem_op, taken, stall, br, lu_raw, lu, lu_hold, err_set;
   load_use_detect u_lud (
      .rs1     (id_rs1),
      .rs2     (id_rs2),
      .use_rs1 (id_use_rs1),
      .use_rs2 (id_use_rs2),
      .memread (id_ex_memread),
      .rd      (id_ex_rd),
      .hazard  (lu_raw)
   );
   assign mem_op = ex_mem_memread | ex_mem_memwrite;
   assign taken  = ex_mem_branch && ex_mem_zero;
   assign stall  = state == MEM_WAIT || (mem_op && !mem_ready);
   assign br     = !stall && taken;
   // lu_hold masks the cycle after a bubble so a held hazard yields a single bubble
   assign lu     = !stall && !taken && lu_raw && !lu_hold;
   assign pc_write      = !reset && !stall && !lu;
   assign pc_src_branch = !reset && br;
   assign if_id_write   = !reset && !stall && !lu;
   assign if_id_flush   = reset || br;
   assign id_ex_write   = !reset && !stall;
   assign id_ex_bubble  = reset || br || lu;
   assign ex_mem_write  = !reset && !stall;
   assign ex_mem_flush  = reset || br;
   assign mem_wb_bubble = reset || stall;
   always_comb begin
      state_n = state;
      wait_n  = wait_cnt;
      err_set = 1'b0;
      if (state == RUN) begin
         if (mem_op && !mem_ready) begin
            state_n = MEM_WAIT;
            wait_n  = 8'd1;
         end
      end else if (mem_ready || wait_cnt >= TMO) begin
         state_n = RUN;
         wait_n  = '0;
         err_set = !mem_ready;
      end else begin
         wait_n  = wait_cnt == 8'hff ? wait_cnt : wait_cnt + 8'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RUN;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
         lu_hold  <= 1'b0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_n;
         mem_err  <= mem_err | err_set;
         lu_hold  <= lu;
      end
   end
`ifdef HAZ_PERF_CNT_EN
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   logic [CNT_W-1:0] stall_q, flush_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_write && stall_q != '1) stall_q <= stall_q + ONE;
         if (pc_src_branch && flush_q != '1) flush_q <= flush_q + ONE;
      end
   end
   assign stall_cycles = stall_q;
   assign flush_events = flush_q;
`else
   assign stall_cycles = '0;
   assign flush_events = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT = 4).
module tb_pipeline_hazard_ctrl;
   // control vector: pc_write, pc_src_branch, if_id_write, if_id_flush, id_ex_write,
   // id_ex_bubble, ex_mem_write, ex_mem_flush, mem_wb_bubble, mem_err
   localparam logic [9:0] NORM  = 10'b1010101000;
   localparam logic [9:0] BR    = 10'b1111111100;
   localparam logic [9:0] LU    = 10'b0000111000;
   localparam logic [9:0] STALL = 10'b0000000010;
   localparam logic [9:0] RST   = 10'b0001010110;
   typedef struct {
      string      tag;
      logic [9:0] e;
   } sb_t;
   logic clk = 1'b0, reset;
   logic [4:0] id_rs1, id_rs2, id_ex_rd;
   logic id_use_rs1, id_use_rs2, id_ex_memread, ex_mem_branch, ex_mem_zero;
   logic ex_mem_memread, ex_mem_memwrite, mem_ready;
   logic pc_write, pc_src_branch, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
   logic ex_mem_write, ex_mem_flush, mem_wb_bubble, mem_err;
   logic [31:0] stall_cycles, flush_events;
   sb_t sb[$];
   int n_chk = 0, n_fail = 0;
   logic [31:0] m_stc = 0, m_fl = 0;
   pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_ex_memread(id_ex_memread),
      .id_ex_rd(id_ex_rd), .ex_mem_branch(ex_mem_branch), .ex_mem_zero(ex_mem_zero),
      .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_src_branch(pc_src_branch), .if_id_write(if_id_write),
      .if_id_flush(if_id_flush), .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble),
      .ex_mem_write(ex_mem_write), .ex_mem_flush(ex_mem_flush), .mem_wb_bubble(mem_wb_bubble),
      .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_events(flush_events)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic clear();
      {id_rs1, id_rs2, id_ex_rd} = '0;
      {id_use_rs1, id_use_rs2, id_ex_memread, ex_mem_branch, ex_mem_zero} = '0;
      {ex_mem_memread, ex_mem_memwrite, mem_ready} = '0;
   endtask
   task automatic step(input string tag, input logic [9:0] e);
      sb_t s;
      logic [31:0] x_stc, x_fl;
      sb.push_back('{tag, e});
      @(negedge clk);
      s = sb.pop_front();
      chk(s.tag, {22'd0, pc_write, pc_src_branch, if_id_write, if_id_flush, id_ex_write,
                  id_ex_bubble, ex_mem_write, ex_mem_flush, mem_wb_bubble, mem_err}, {22'd0, s.e});
`ifdef HAZ_PERF_CNT_EN
      x_stc = m_stc;
      x_fl  = m_fl;
`else
      x_stc = 0;
      x_fl  = 0;
`endif
      chk({s.tag, "_stall_cnt"}, stall_cycles, x_stc);
      chk({s.tag, "_flush_cnt"}, flush_events, x_fl);
      if (reset) begin
         m_stc = 0;
         m_fl  = 0;
      end else begin
         if (!s.e[9]) m_stc++;
         if (s.e[8]) m_fl++;
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      clear();
      reset = 1'b1;
      @(posedge clk);
      #1;
      step("reset", RST);
      reset = 1'b0;
      step("idle", NORM);
      id_ex_memread = 1; id_ex_rd = 10; id_rs1 = 10; id_use_rs1 = 1;
      step("lu_rs1", LU);
      step("lu_once", NORM);
      clear();
      id_ex_memread = 1; id_use_rs1 = 1;
      step("lu_x0", NORM);
      clear();
      id_ex_memread = 1; id_ex_rd = 7; id_rs1 = 3; id_rs2 = 7; id_use_rs1 = 1; id_use_rs2 = 1;
      step("lu_rs2", LU);
      clear();
      id_ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; id_ex_memread = 1;
      step("lu_gap", NORM);
      id_use_rs2 = 0;
      step("lu_nouse", NORM);
      clear();
      ex_mem_branch = 1; ex_mem_zero = 1;
      step("br_taken", BR);
      ex_mem_zero = 0;
      step("br_not", NORM);
      clear();
      ex_mem_memread = 1; mem_ready = 1;
      step("mem_zero_lat", NORM);
      mem_ready = 0;
      for (int i = 0; i < 3; i++) step("mem_wait", STALL);
      mem_ready = 1;
      step("mem_rdy", STALL);
      clear();
      step("mem_run", NORM);
      ex_mem_memread = 1; ex_mem_branch = 1; ex_mem_zero = 1;
      step("mem_br", STALL);
      mem_ready = 1;
      step("mem_br_rdy", STALL);
      clear();
      step("mem_br_run", NORM);
      ex_mem_memwrite = 1;
      for (int i = 0; i < 5; i++) step("tmo_wait", STALL);
      clear();
      step("tmo_rel", NORM | 10'd1);
      step("tmo_sticky", NORM | 10'd1);
      reset = 1;
      step("tmo_rst", RST | 10'd1);
      reset = 0;
      step("tmo_clr", NORM);
      id_ex_memread = 1; id_ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
      ex_mem_memread = 1;
      step("pri_stall", STALL);
      mem_ready = 1;
      step("pri_rdy", STALL);
      ex_mem_memread = 0; mem_ready = 0;
      step("pri_lu", LU);
      step("pri_lu_once", NORM);
      clear();
      ex_mem_memread = 1;
      step("rw_stall", STALL);
      step("rw_wait", STALL);
      reset = 1;
      step("rw_reset", RST);
      reset = 0;
      clear();
      step("rw_run", NORM);
      ex_mem_memwrite = 1;
      for (int i = 0; i < 5; i++) step("rw_cnt", STALL);
      clear();
      step("rw_tmo", NORM | 10'd1);
      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
